// File: rtl/project_pwm_update_scheduler.sv
// Shadow-write scheduler: host register writes are queued and committed to the
// PWM register file as one atomic batch on a selectable counter event.
module project_pwm_update_scheduler #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 6,
  parameter int PTR_W  = 3
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [7:0]        i_data,
  input  logic [1:0]        i_commit_mode,
  input  logic              i_commit_req,
  input  logic [15:0]       i_counter,
  input  logic [15:0]       i_period,
  input  logic              i_clear_overflow,
  output logic              o_reg_we,
  output logic [ADDR_W-1:0] o_reg_address,
  output logic [7:0]        o_reg_data,
  output logic [PTR_W:0]    o_level,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_busy,
  output logic              o_overflow
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DRAIN} state_e;
  typedef enum logic [1:0] {
    MODE_IMM    = 2'b00,
    MODE_ZERO   = 2'b01,
    MODE_PERIOD = 2'b10,
    MODE_MANUAL = 2'b11
  } mode_e;

  localparam int             ENTRY_W = ADDR_W + 8;
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  state_e             state_q;
  logic [PTR_W:0]     wr_ptr_q, rd_ptr_q, rem_q, level;
  logic [15:0]        prev_counter_q;
  logic               reg_we_q, overflow_q;
  logic [ADDR_W-1:0]  reg_address_q;
  logic [7:0]         reg_data_q;
  logic               full, empty, push, pop;
  logic               zero_evt, period_evt, commit_evt;

  // Pointers carry an extra MSB so a full FIFO is distinguishable from an empty one.
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == DEPTH_L);
  assign empty = (level == '0);
  assign push  = i_wr_en && !full;

  // Edge-qualified events: a counter parked on zero/period fires only once.
  assign zero_evt   = (i_counter == 16'd0) && (prev_counter_q != 16'd0);
  assign period_evt = (i_counter == i_period) && (prev_counter_q != i_period);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    commit_evt = 1'b0;
    case (mode_e'(i_commit_mode))
      MODE_IMM:    commit_evt = 1'b1;
      MODE_ZERO:   commit_evt = zero_evt;
      MODE_PERIOD: commit_evt = period_evt;
      MODE_MANUAL: commit_evt = i_commit_req;
      default:     commit_evt = 1'b0;
    endcase
  end

  // The first entry of a batch is popped on the event edge itself; rem_q counts the rest.
  assign pop = ((state_q == S_ARMED) && commit_evt && !empty) ||
               ((state_q == S_DRAIN) && (rem_q != '0));

  // NOTE: FIFO storage is deliberately not reset; the pointers alone define valid entries.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= {i_address, i_data};
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      rem_q          <= '0;
      prev_counter_q <= '0;
      reg_we_q       <= 1'b0;
      reg_address_q  <= '0;
      reg_data_q     <= '0;
      overflow_q     <= 1'b0;
    end else begin
      prev_counter_q <= i_counter;
      reg_we_q       <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q                     <= rd_ptr_q + 1'b1;
        {reg_address_q, reg_data_q}  <= mem_q[rd_ptr_q[PTR_W-1:0]];
      end
      if (i_wr_en && full)        overflow_q <= 1'b1;
      else if (i_clear_overflow)  overflow_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (push) state_q <= S_ARMED;
        end
        S_ARMED: begin
          if (pop) begin
            state_q <= S_DRAIN;
            rem_q   <= level - 1'b1;
          end
        end
        S_DRAIN: begin
          if (rem_q != '0) rem_q   <= rem_q - 1'b1;
          else             state_q <= (!empty || push) ? S_ARMED : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_reg_we      = reg_we_q;
  assign o_reg_address = reg_address_q;
  assign o_reg_data    = reg_data_q;
  assign o_level       = level;
  assign o_full        = full;
  assign o_empty       = empty;
  assign o_busy        = (state_q == S_DRAIN);
  assign o_overflow    = overflow_q;

endmodule
